bus_drive_sequencer: RTL and testbench



---
 rtl/bus_seq_pkg.sv | 27 ++
 rtl/rr_arbiter.sv | 52 +++++
 rtl/bus_drive_sequencer.sv | 184 ++++++++++++++++++
 tb/tb_bus_drive_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_seq_pkg.sv
// -----------------------------------------------------------------------------
// bus_seq_pkg
// Shared definitions for the bus drive sequencer and the bus masters that reuse
// its round-robin arbiter.
//   state_t       : sequencer states (ST_PARK is reached only when the top is
//                   built with BUS_SEQ_PARK_EN defined)
//   DEF_TURN      : default number of dead cycles between bus owners
//   DEF_HOLD_MAX  : default DRIVE cycles allowed while another source waits
//   idx_w()       : width of an index into N sources (at least 1 bit)
// -----------------------------------------------------------------------------
package bus_seq_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_TURN  = 2'd1,
      ST_DRIVE = 2'd2,
      ST_PARK  = 2'd3
   } state_t;

   localparam int unsigned DEF_TURN     = 1;
   localparam int unsigned DEF_HOLD_MAX = 16;

   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin pick. The search begins at index 'start' and wraps;
// the first requesting index wins. When mask_en is set, index mask_idx is
// excluded from the search (used to keep a releasing owner off the bus).
// Ports:
//   req       in  N   request vector, active-high
//   mask_en   in  1   exclude mask_idx from the search
//   mask_idx  in  W   index to exclude
//   start     in  W   first index examined
//   gnt_oh    out N   one-hot winner (all zero when nothing eligible)
//   gnt_idx   out W   winner index (0 when nothing eligible)
// -----------------------------------------------------------------------------
module rr_arbiter
   import bus_seq_pkg::*;
#(
   parameter int unsigned N = 4,
   parameter int unsigned W = idx_w(N)
) (
   input  logic [N-1:0] req,
   input  logic         mask_en,
   input  logic [W-1:0] mask_idx,
   input  logic [W-1:0] start,
   output logic [N-1:0] gnt_oh,
   output logic [W-1:0] gnt_idx
);

   localparam logic [W-1:0] LAST = W'(N - 1);

   logic [N-1:0] eligible;
   logic [W-1:0] probe;
   logic         found;

   always_comb begin
      // NOTE: every variable gets a default at the top of a combinational
      // block so no path leaves it unassigned, which would infer a latch.
      eligible = req & ~(mask_en ? (N'(1) << mask_idx) : '0);
      gnt_oh   = '0;
      gnt_idx  = '0;
      found    = 1'b0;
      probe    = start;
      for (int i = 0; i < int'(N); i++) begin
         if (!found && (|(eligible & (N'(1) << probe)))) begin
            found   = 1'b1;
            gnt_oh  = N'(1) << probe;
            gnt_idx = probe;
         end
         probe = (probe == LAST) ? '0 : probe + W'(1);
      end
   end

endmodule

// File: rtl/bus_drive_sequencer.sv
// -----------------------------------------------------------------------------
// bus_drive_sequencer
// Generates the active-low output enables for a bank of inverting tri-state
// bus buffers sharing one bus. Sources are served round-robin; exactly one
// enable is low at a time and TURN all-high dead cycles separate owners.
// An owner is force-released after HOLD_MAX cycles if another source waits.
//
// Optional feature: define BUS_SEQ_PARK_EN to keep the last owner's buffer
// enabled (PARK) while the bus is otherwise unrequested; the same owner can
// then resume without a turnaround.
//
// Ports:
//   CLK    in   1     rising-edge clock
//   RESET  in   1     synchronous, active-high reset
//   REQ    in   NSRC  per-source level request
//   ENB_N  out  NSRC  per-buffer output enable, active-low, registered
//   GNT    out  NSRC  one-hot grant, registered
//   BUSY   out  1     high whenever the sequencer is not IDLE
//   OWNER  out  W     index of current or last owner
// -----------------------------------------------------------------------------
module bus_drive_sequencer
   import bus_seq_pkg::*;
#(
   parameter int unsigned NSRC     = 4,
   parameter int unsigned TURN     = DEF_TURN,
   parameter int unsigned HOLD_MAX = DEF_HOLD_MAX
) (
   input  logic                   CLK,
   input  logic                   RESET,
   input  logic [NSRC-1:0]        REQ,
   output logic [NSRC-1:0]        ENB_N,
   output logic [NSRC-1:0]        GNT,
   output logic                   BUSY,
   output logic [idx_w(NSRC)-1:0] OWNER
);

   localparam int unsigned OW = idx_w(NSRC);
   localparam int unsigned TW = $clog2(TURN + 1);
   localparam int unsigned HW = $clog2(HOLD_MAX + 1);

   localparam logic [OW-1:0] LAST_IDX = OW'(NSRC - 1);
   localparam logic [TW-1:0] TURN_LD  = TW'(TURN);
   localparam logic [HW-1:0] HOLD_SAT = HW'(HOLD_MAX);
   localparam logic [HW-1:0] HOLD_LIM = HW'(HOLD_MAX - 1);

`ifdef BUS_SEQ_PARK_EN
   localparam state_t REST_STATE = ST_PARK;
`else
   localparam state_t REST_STATE = ST_IDLE;
`endif

   state_t            state_q, state_nxt;
   logic [OW-1:0]     owner_q;
   logic [OW-1:0]     win_idx_q;
   logic [NSRC-1:0]   win_oh_q;
   logic [TW-1:0]     turn_cnt_q;
   logic [HW-1:0]     hold_cnt_q;
   logic [NSRC-1:0]   enb_n_q, enb_n_nxt;
   logic [NSRC-1:0]   gnt_q, gnt_nxt;

   logic [NSRC-1:0]   owner_oh;
   logic [NSRC-1:0]   others;
   logic              owner_req;
   logic              drive_release;
   logic [OW-1:0]     start_idx;
   logic [NSRC-1:0]   arb_oh;
   logic [OW-1:0]     arb_idx;
   logic              enter_turn;
   logic              enter_drive;

   assign owner_oh  = NSRC'(1) << owner_q;
   assign others    = REQ & ~owner_oh;
   assign owner_req = |(REQ & owner_oh);
   assign start_idx = (owner_q == LAST_IDX) ? '0 : owner_q + OW'(1);

   // Forced release only when someone else is waiting, so a forced release
   // always has a successor to arbitrate for.
   assign drive_release = !owner_req || ((hold_cnt_q == HOLD_LIM) && (|others));

   // Outside IDLE the owner is leaving the bus, so it is kept out of the pick;
   // from IDLE every requester, including the last owner, is eligible.
   rr_arbiter #(
      .N (NSRC),
      .W (OW)
   ) u_arb (
      .req      (REQ),
      .mask_en  (state_q != ST_IDLE),
      .mask_idx (owner_q),
      .start    (start_idx),
      .gnt_oh   (arb_oh),
      .gnt_idx  (arb_idx)
   );

   // State register
   always_ff @(posedge CLK) begin
      // NOTE: sequential state uses non-blocking assignments so every register
      // samples the pre-edge values regardless of statement order.
      if (RESET) state_q <= ST_IDLE;
      else       state_q <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state_q;
      case (state_q)
         ST_IDLE:  if (|REQ) state_nxt = ST_TURN;
         ST_TURN:  if (turn_cnt_q <= TW'(1)) state_nxt = ST_DRIVE;
         ST_DRIVE: if (drive_release) state_nxt = (|others) ? ST_TURN : REST_STATE;
`ifdef BUS_SEQ_PARK_EN
         // Another source outranks the parked owner's own request.
         ST_PARK: begin
            if (|others)        state_nxt = ST_TURN;
            else if (owner_req) state_nxt = ST_DRIVE;
         end
`endif
         default:  state_nxt = ST_IDLE;
      endcase
   end

   assign enter_turn  = (state_nxt == ST_TURN)  && (state_q != ST_TURN);
   assign enter_drive = (state_nxt == ST_DRIVE) && (state_q != ST_DRIVE);

   // Output decode: enables and grant are a function of the state being
   // entered, then registered, so they change on the same edge as the state.
   always_comb begin
      enb_n_nxt = '1;
      gnt_nxt   = '0;
      case (state_nxt)
         ST_DRIVE: begin
            if (state_q == ST_TURN) begin
               enb_n_nxt = ~win_oh_q;
               gnt_nxt   = win_oh_q;
            end else begin
               enb_n_nxt = ~owner_oh;
               gnt_nxt   = owner_oh;
            end
         end
         ST_PARK: enb_n_nxt = ~owner_oh;
         default: ;
      endcase
   end

   // Counters, winner latch, owner and output registers
   always_ff @(posedge CLK) begin
      // NOTE: all control registers are reset here; there is no storage array
      // that could be left unreset.
      if (RESET) begin
         owner_q    <= LAST_IDX;
         win_idx_q  <= '0;
         win_oh_q   <= '0;
         turn_cnt_q <= '0;
         hold_cnt_q <= '0;
         enb_n_q    <= '1;
         gnt_q      <= '0;
      end else begin
         enb_n_q <= enb_n_nxt;
         gnt_q   <= gnt_nxt;

         // The winner is frozen on entry to TURN; later REQ changes are not
         // re-examined until the winner has had its DRIVE cycle.
         if (enter_turn) begin
            win_idx_q  <= arb_idx;
            win_oh_q   <= arb_oh;
            turn_cnt_q <= TURN_LD;
         end else if ((state_q == ST_TURN) && (turn_cnt_q != '0)) begin
            turn_cnt_q <= turn_cnt_q - TW'(1);
         end

         if (enter_drive) begin
            hold_cnt_q <= '0;
         end else if ((state_q == ST_DRIVE) && (hold_cnt_q != HOLD_SAT)) begin
            hold_cnt_q <= hold_cnt_q + HW'(1);
         end

         if ((state_q == ST_TURN) && (state_nxt == ST_DRIVE)) owner_q <= win_idx_q;
      end
   end

   assign ENB_N = enb_n_q;
   assign GNT   = gnt_q;
   assign OWNER = owner_q;
   assign BUSY  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_bus_drive_sequencer.sv
// -----------------------------------------------------------------------------
// tb_bus_drive_sequencer
// Directed bench for bus_drive_sequencer. A TURN=1 instance runs a table of
// per-cycle vectors plus hold-limit and reset sequences; a TURN=3 instance
// measures grant latency and the handover gap. The park sequence is present
// when BUS_SEQ_PARK_EN is defined.
// -----------------------------------------------------------------------------
module tb_bus_drive_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req, req3;
   logic [3:0] enb_n, gnt, enb3_n, gnt3;
   logic       busy, busy3;
   logic [1:0] owner, owner3;

   int n_cmp  = 0;
   int n_fail = 0;

`ifdef BUS_SEQ_PARK_EN
   localparam bit PARK = 1'b1;
`else
   localparam bit PARK = 1'b0;
`endif

   always #5 clk = ~clk;

   bus_drive_sequencer #(.NSRC(4), .TURN(1), .HOLD_MAX(16)) dut (
      .CLK   (clk),
      .RESET (rst),
      .REQ   (req),
      .ENB_N (enb_n),
      .GNT   (gnt),
      .BUSY  (busy),
      .OWNER (owner)
   );

   bus_drive_sequencer #(.NSRC(4), .TURN(3), .HOLD_MAX(16)) dut3 (
      .CLK   (clk),
      .RESET (rst),
      .REQ   (req3),
      .ENB_N (enb3_n),
      .GNT   (gnt3),
      .BUSY  (busy3),
      .OWNER (owner3)
   );

   typedef struct {
      logic [3:0] req;
      logic [3:0] enb_n;
      logic [3:0] gnt;
      logic       busy;
      logic [1:0] owner;
   } vec_t;

   vec_t vecs[14];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_outs(input string tag, input logic [3:0] e_enb, input logic [3:0] e_gnt,
                             input logic e_busy, input logic [1:0] e_owner);
      check({tag, ".enb_n"}, 32'(enb_n), 32'(e_enb));
      check({tag, ".gnt"},   32'(gnt),   32'(e_gnt));
      check({tag, ".busy"},  32'(busy),  32'(e_busy));
      check({tag, ".owner"}, 32'(owner), 32'(e_owner));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [3:0] prev_gnt, exp_oh, inv_gnt;
      int run_len, gap_len, n_runs, exp_idx, lat, gap;
      bit done;

      // {req applied, enb_n, gnt, busy, owner after the following edge}
      vecs[0]  = '{4'b0001, 4'b1111, 4'b0000, 1'b1, 2'd3};
      vecs[1]  = '{4'b0001, 4'b1110, 4'b0001, 1'b1, 2'd0};
      vecs[2]  = '{4'b0001, 4'b1110, 4'b0001, 1'b1, 2'd0};
      vecs[3]  = '{4'b0110, 4'b1111, 4'b0000, 1'b1, 2'd0};
      vecs[4]  = '{4'b0110, 4'b1101, 4'b0010, 1'b1, 2'd1};
      vecs[5]  = '{4'b0100, 4'b1111, 4'b0000, 1'b1, 2'd1};
      vecs[6]  = '{4'b0100, 4'b1011, 4'b0100, 1'b1, 2'd2};
      vecs[7]  = '{4'b0000, PARK ? 4'b1011 : 4'b1111, 4'b0000, PARK, 2'd2};
      vecs[8]  = '{4'b0000, PARK ? 4'b1011 : 4'b1111, 4'b0000, PARK, 2'd2};
      vecs[9]  = '{4'b1001, 4'b1111, 4'b0000, 1'b1, 2'd2};
      vecs[10] = '{4'b0001, 4'b0111, 4'b1000, 1'b1, 2'd3};
      vecs[11] = '{4'b0001, 4'b1111, 4'b0000, 1'b1, 2'd3};
      vecs[12] = '{4'b0001, 4'b1110, 4'b0001, 1'b1, 2'd0};
      vecs[13] = '{4'b0000, PARK ? 4'b1110 : 4'b1111, 4'b0000, PARK, 2'd0};

      rst  = 1'b1;
      req  = 4'b0000;
      req3 = 4'b0000;
      tick();
      tick();
      check_outs("reset", 4'b1111, 4'b0000, 1'b0, 2'd3);
      check("reset3.enb_n", 32'(enb3_n), 32'hF);
      check("reset3.owner", 32'(owner3), 32'd3);
      rst = 1'b0;

      // Table: grant latency, handover with same-cycle new requests, round-
      // robin order from the last owner, and a REQ dropped during TURN.
      for (int i = 0; i < 14; i++) begin
         req = vecs[i].req;
         tick();
         check_outs($sformatf("vec%0d", i), vecs[i].enb_n, vecs[i].gnt, vecs[i].busy, vecs[i].owner);
      end

      // Two sources requesting continuously: each holds exactly HOLD_MAX
      // cycles, grants alternate 0,1,0,1 with one dead cycle between owners.
      rst = 1'b1;
      req = 4'b0000;
      tick();
      rst      = 1'b0;
      req      = 4'b0011;
      prev_gnt = 4'b0000;
      run_len  = 0;
      gap_len  = 0;
      n_runs   = 0;
      exp_idx  = 0;
      for (int c = 0; c < 80; c++) begin
         tick();
         check("hold.one_low", 32'($countones(~enb_n) <= 1), 32'd1);
         inv_gnt = ~gnt;
         check("hold.enb_vs_gnt", 32'(enb_n), 32'(inv_gnt));
         if (gnt != 4'b0000) begin
            if (prev_gnt == 4'b0000) begin
               check("hold.gap", 32'(gap_len), 32'd1);
               exp_oh = 4'b0001 << exp_idx;
               check("hold.order", 32'(gnt), 32'(exp_oh));
               exp_idx = exp_idx ^ 1;
               run_len = 1;
            end else begin
               check("hold.stable", 32'(gnt), 32'(prev_gnt));
               run_len++;
            end
            gap_len = 0;
         end else begin
            if (prev_gnt != 4'b0000) begin
               check("hold.run_len", 32'(run_len), 32'd16);
               n_runs++;
            end
            gap_len++;
         end
         prev_gnt = gnt;
      end
      check("hold.n_runs", 32'(n_runs), 32'd4);

      // Reset while source 0 is driving, then source 3 is served first.
      check("mid.driving", 32'(gnt), 32'b0001);
      rst = 1'b1;
      tick();
      check_outs("mid_reset", 4'b1111, 4'b0000, 1'b0, 2'd3);
      rst = 1'b0;
      req = 4'b1000;
      tick();
      check_outs("post_reset.turn", 4'b1111, 4'b0000, 1'b1, 2'd3);
      tick();
      check_outs("post_reset.drive", 4'b0111, 4'b1000, 1'b1, 2'd3);
      req = 4'b0000;
      tick();

      // TURN=3 instance: latency from IDLE and the handover gap.
      req3 = 4'b0001;
      lat  = 99;
      done = 1'b0;
      for (int c = 0; c < 12 && !done; c++) begin
         tick();
         if (c == 0) check("t3.busy", 32'(busy3), 32'd1);
         if (gnt3 != 4'b0000) begin
            lat  = c + 1;
            done = 1'b1;
         end
      end
      check("t3.latency", 32'(lat), 32'd4);
      check("t3.gnt0", 32'(gnt3), 32'b0001);
      req3 = 4'b0010;
      gap  = 0;
      done = 1'b0;
      for (int c = 0; c < 20 && !done; c++) begin
         tick();
         if (gnt3 == 4'b0010) done = 1'b1;
         else if (enb3_n == 4'b1111) gap++;
      end
      check("t3.granted", 32'(done), 32'd1);
      check("t3.gap", 32'(gap), 32'd3);
      check("t3.enb_n", 32'(enb3_n), 32'b1101);
      check("t3.owner", 32'(owner3), 32'd1);
      req3 = 4'b0000;
      tick();

`ifdef BUS_SEQ_PARK_EN
      // Owner 2 drops for three cycles and resumes without turnaround; then
      // source 0 requests from PARK and pays a turnaround.
      rst = 1'b1;
      tick();
      rst = 1'b0;
      req = 4'b0100;
      tick();
      tick();
      check_outs("park.drive2", 4'b1011, 4'b0100, 1'b1, 2'd2);
      req = 4'b0000;
      for (int c = 0; c < 3; c++) begin
         tick();
         check_outs($sformatf("park.hold%0d", c), 4'b1011, 4'b0000, 1'b1, 2'd2);
      end
      req = 4'b0100;
      tick();
      check_outs("park.resume", 4'b1011, 4'b0100, 1'b1, 2'd2);
      req = 4'b0000;
      tick();
      check_outs("park.again", 4'b1011, 4'b0000, 1'b1, 2'd2);
      req = 4'b0001;
      tick();
      check_outs("park.turn", 4'b1111, 4'b0000, 1'b1, 2'd2);
      tick();
      check_outs("park.src0", 4'b1110, 4'b0001, 1'b1, 2'd0);
      req = 4'b0000;
      tick();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
